// File: rtl/cpu_types_pkg.sv
// Shared fetch-side types for the direct-mapped instruction cache:
// word type, default address-field widths, frame layout and cache FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int ISETS = 16;
   localparam int IIDXW = $clog2(ISETS);
   localparam int IBYTW = 2;
   localparam int ITAGW = 32 - IIDXW - IBYTW;

   typedef struct packed {
      logic [ITAGW-1:0] tag;
      logic [IIDXW-1:0] idx;
      logic [IBYTW-1:0] bytoff;
   } icachef_t;

   typedef struct packed {
      logic             valid;
      logic [ITAGW-1:0] tag;
      word_t            data;
   } icache_frame_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   function automatic word_t word_align(input logic [29:0] word_addr);
      return {word_addr, 2'b00};
   endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block, read-only instruction cache with a single-fill FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm
   import cpu_types_pkg::*;
#(
   parameter int SETS = ISETS
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDXW = $clog2(SETS);
   localparam int TAGW = 30 - IDXW;

   icache_state_t    state_q, state_d;
   logic [SETS-1:0]  valid_q, valid_d;
   logic [TAGW-1:0]  tag_q  [SETS];
   word_t            data_q [SETS];
   word_t            fill_addr_q, fill_addr_d;
   logic             iren_q, iren_d;
   word_t            iaddr_q, iaddr_d;

   logic [TAGW-1:0]  req_tag_s;
   logic [IDXW-1:0]  req_idx_s;
   logic [TAGW-1:0]  fill_tag_s;
   logic [IDXW-1:0]  fill_idx_s;
   logic             hit_s;
   logic             fill_done_s;
   logic             miss_start_s;
   logic             unused_ok_s;

   assign req_tag_s   = imemaddr[31:IDXW+2];
   assign req_idx_s   = imemaddr[IDXW+1:2];
   assign fill_tag_s  = fill_addr_q[31:IDXW+2];
   assign fill_idx_s  = fill_addr_q[IDXW+1:2];
   assign unused_ok_s = ^{imemaddr[1:0], fill_addr_q[1:0]};

   // Same-cycle hit detection and read data steering.
   always_comb begin
      hit_s    = 1'b0;
      imemload = 32'h0000_0000;
      if (imemREN && (state_q == IDLE) && valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s)) begin
         hit_s    = 1'b1;
         imemload = data_q[req_idx_s];
      end else begin
         hit_s    = 1'b0;
         imemload = 32'h0000_0000;
      end
   end

   assign ihit  = hit_s;
   assign iREN  = iren_q;
   assign iaddr = iaddr_q;

   // FSM next-state, fill bookkeeping and valid-bit update.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      fill_addr_d  = fill_addr_q;
      iren_d       = iren_q;
      iaddr_d      = iaddr_q;
      fill_done_s  = 1'b0;
      miss_start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (imemREN && !hit_s) begin
               state_d      = FILL;
               fill_addr_d  = word_align(imemaddr[31:2]);
               iren_d       = 1'b1;
               iaddr_d      = word_align(imemaddr[31:2]);
               miss_start_s = 1'b1;
            end else begin
               state_d      = IDLE;
               miss_start_s = 1'b0;
            end
         end
         FILL: begin
            // The fill always finishes to the latched address, whatever the fetch port does.
            if (!iwait) begin
               state_d             = IDLE;
               valid_d[fill_idx_s] = 1'b1;
               iren_d              = 1'b0;
               iaddr_d             = 32'h0000_0000;
               fill_done_s         = 1'b1;
            end else begin
               state_d     = FILL;
               fill_done_s = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            iren_d  = 1'b0;
            iaddr_d = 32'h0000_0000;
         end
      endcase
   end

   // FSM state, valid bits and registered fill-port outputs.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         fill_addr_q <= 32'h0000_0000;
         iren_q      <= 1'b0;
         iaddr_q     <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         fill_addr_q <= fill_addr_d;
         iren_q      <= iren_d;
         iaddr_q     <= iaddr_d;
      end
   end

   // Tag and data arrays carry no reset; a reset edge never commits a fill.
   always_ff @(posedge CLK) begin
      if (nRST && fill_done_s) begin
         tag_q[fill_idx_s]  <= fill_tag_s;
         data_q[fill_idx_s] <= iload;
      end
   end

`ifdef ICACHE_STATS_EN
   logic  replay_q, replay_d;
   word_t hit_cnt_q, hit_cnt_d;
   word_t miss_cnt_q, miss_cnt_d;

   // Saturating counters; the replay hit right after a fill is not a true hit.
   always_comb begin
      replay_d = fill_done_s;
      if (hit_s && !replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
         hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
         hit_cnt_d = hit_cnt_q;
      end
      if (miss_start_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
         miss_cnt_d = miss_cnt_q + 32'd1;
      end else begin
         miss_cnt_d = miss_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         replay_q   <= 1'b0;
         hit_cnt_q  <= 32'h0000_0000;
         miss_cnt_q <= 32'h0000_0000;
      end else begin
         replay_q   <= replay_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, one-word-per-block instruction cache between the datapath fetch port and the memory controller's instruction request port.
- Hits serve instructions in the same cycle.
- Misses run a single fill transaction to the memory controller, then replay as a hit.
- Read-only block: no dirty state and no write-back.

Parameters:
- SETS, 16, number of frames; power of two, minimum 2.
- IDXW, $clog2(SETS), index width (derived, not overridden).
- TAGW, 30-IDXW, tag width (derived).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on CLK rising edge.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  imemload valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  fill request to memory controller.
- iaddr  output  32  fill address, word aligned.
- iwait  input  1  high while the fill is not yet complete.
- iload  input  32  fill data; valid in the cycle iwait is low.

Behaviour:
- Address split: tag = imemaddr[31:IDXW+2], idx = imemaddr[IDXW+1:2], byte offset = [1:0].
- Frame contents: valid bit, TAGW-bit tag, 32-bit data.
- Hit is combinational: ihit = imemREN & (state==IDLE) & valid[idx] & (tag[idx]==tag). imemload = data[idx] whenever hit, else 0.
- FSM states: IDLE, FILL.
- IDLE: on imemREN with no hit, go to FILL next edge and latch fill_addr = {imemaddr[31:2],2'b00}.
- FILL:
  - iREN=1, iaddr=fill_addr.
  - When iwait=0: write valid=1, tag and data into the frame at fill_addr's index, and return to IDLE.
  - The replayed access hits in the next cycle.
  - Miss latency = 1 (IDLE->FILL) + memory cycles until iwait low + 1 replay.
- If imemREN drops or imemaddr changes during FILL, the fill still completes to the latched address. It is never abandoned mid-transaction.
- Outputs are 0 in IDLE (iREN=0, iaddr=0) and whenever ihit=0 (imemload=0).
- Conflict miss: a fill overwrites the resident frame; there is no victim handling.
- Reset (synchronous, any state including mid-FILL):
  - state=IDLE, all valid bits=0, fill_addr=0.
  - Tag and data arrays need not be reset.
  - iREN drops in the cycle after the reset edge.
- imemREN=0 in IDLE: no state change, ihit=0.
- Invariant: ihit and iREN are never high in the same cycle.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds two outputs, hit_count[31:0] and miss_count[31:0].
  - hit_count increments on every cycle with ihit=1, except the replay hit that immediately follows a fill.
  - miss_count increments on every IDLE->FILL transition.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared types package cpu_types_pkg holds:
  - word_t (32 bits).
  - Parameterized address-field constants ITAGW, IIDXW, IBYTW=2.
  - Packed struct icachef_t {tag, idx, bytoff}.
  - Frame struct icache_frame_t {valid, tag, data}.
  - FSM enum icache_state_t {IDLE, FILL}.
- No sub-module: frame array, FSM and compare logic stay in one module.

Test Plan:
1. Reset, then imemREN=1, imemaddr=0x00000040 -> ihit=0; FSM goes to FILL next cycle with iREN=1, iaddr=0x40. Hold iwait=1 for 3 cycles, then iwait=0 with iload=0x2001000A -> the next cycle gives ihit=1, imemload=0x2001000A, iREN=0.
2. After 1, imemaddr=0x00000043 -> same-cycle ihit=1, imemload=0x2001000A (offset ignored).
3. Conflict: fill 0x40, then 0x440 with SETS=16 (same idx 0, different tag) -> 0x440 misses and fills; re-access of 0x40 then misses again, with iaddr=0x40.
4. During FILL for 0x80, change imemaddr to 0xC0 and drop imemREN -> iaddr stays 0x80 until iwait=0; the frame for 0x80 becomes valid; the later access to 0xC0 misses.
5. Assert nRST=0 for one edge mid-FILL -> iREN=0 next cycle; a previously filled 0x40 now misses.
6. With ICACHE_STATS_EN defined, run scenarios 1 and 2 -> miss_count=1, hit_count=1.
